// File: rtl/hazard_if.sv
// Pipeline hazard-control bundle: ID/EX/MEM stage inputs and the buffer
// write/bubble/flush controls plus statistics returned by the controller.
interface hazard_if #(
  parameter int unsigned CNT_W = 16
);
  logic [5:0]       id_rs;
  logic [5:0]       id_rt;
  logic             id_uses_rt;
  logic [5:0]       ex_rd;
  logic             ex_RegWrite;
  logic [5:0]       mem_rd;
  logic             mem_RegWrite;
  logic             mem_Z;
  logic             mem_N;
  logic             mem_BrZ;
  logic             mem_BrN;
  logic             mem_jump;
  logic             mem_jump_mem;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rd, ex_RegWrite, mem_rd, mem_RegWrite,
           mem_Z, mem_N, mem_BrZ, mem_BrN, mem_jump, mem_jump_mem,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush,
           stall_cycles, flush_events
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rd, ex_RegWrite, mem_rd, mem_RegWrite,
           mem_Z, mem_N, mem_BrZ, mem_BrN, mem_jump, mem_jump_mem,
    output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush,
           stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall and branch/jump flush controller for a 5-stage pipeline,
// with saturating stall-cycle and flush-event counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  hazard_if.slave bus
);

  typedef enum logic {IDLE, STALL} state_t;

  state_t           state, state_nxt;
  logic [1:0]       rem, rem_nxt;
  logic             taken;
  logic             ex_hit;
  logic             mem_hit;
  logic [1:0]       need;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Register 0 is hardwired zero, so it never creates a dependency.
  always_comb begin
    taken   = (bus.mem_BrZ & bus.mem_Z) | (bus.mem_BrN & bus.mem_N) |
              bus.mem_jump | bus.mem_jump_mem;
    ex_hit  = bus.ex_RegWrite && (bus.ex_rd != 6'd0) &&
              ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));
    mem_hit = bus.mem_RegWrite && (bus.mem_rd != 6'd0) &&
              ((bus.mem_rd == bus.id_rs) || (bus.mem_rd == bus.id_rt && bus.id_uses_rt));
    need    = ex_hit ? 2'd2 : (mem_hit ? 2'd1 : 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= 2'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    case (state)
      IDLE: begin
        if (taken) begin
          rem_nxt = 2'd0;
        end else if (need == 2'd2) begin
          state_nxt = STALL;
          rem_nxt   = 2'd1;
        end
      end
      STALL: begin
        if (taken) begin
          state_nxt = IDLE;
          rem_nxt   = 2'd0;
        end else begin
          rem_nxt = rem - 2'd1;
          if (rem <= 2'd1) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        rem_nxt   = 2'd0;
      end
    endcase
  end

  // Mealy controls; flush always wins over stall, reset forces the free-run values.
  always_comb begin
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.idex_bubble = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    bus.exmem_flush = 1'b0;
    if (rst_n) begin
      if (taken) begin
        bus.ifid_flush  = 1'b1;
        bus.idex_flush  = 1'b1;
        bus.exmem_flush = 1'b1;
      end else if ((state == STALL) || (need != 2'd0)) begin
        bus.pc_write    = 1'b0;
        bus.ifid_write  = 1'b0;
        bus.idex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.idex_bubble && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (taken && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_events = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a countdown model,
// using a 16-bit and a 4-bit counter instance driven from the same inputs.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       uses_rt, ex_we, mem_we, z, n, brz, brn, jmp, jmem;

  int checks = 0;
  int errors = 0;
  int pend = 0;
  int sc16 = 0, fe16 = 0, sc4 = 0, fe4 = 0;

  always #5 clk = ~clk;

  hazard_if #(.CNT_W(16)) b16 ();
  hazard_if #(.CNT_W(4))  b4 ();

  assign b16.id_rs = id_rs;        assign b4.id_rs = id_rs;
  assign b16.id_rt = id_rt;        assign b4.id_rt = id_rt;
  assign b16.id_uses_rt = uses_rt; assign b4.id_uses_rt = uses_rt;
  assign b16.ex_rd = ex_rd;        assign b4.ex_rd = ex_rd;
  assign b16.ex_RegWrite = ex_we;  assign b4.ex_RegWrite = ex_we;
  assign b16.mem_rd = mem_rd;      assign b4.mem_rd = mem_rd;
  assign b16.mem_RegWrite = mem_we; assign b4.mem_RegWrite = mem_we;
  assign b16.mem_Z = z;            assign b4.mem_Z = z;
  assign b16.mem_N = n;            assign b4.mem_N = n;
  assign b16.mem_BrZ = brz;        assign b4.mem_BrZ = brz;
  assign b16.mem_BrN = brn;        assign b4.mem_BrN = brn;
  assign b16.mem_jump = jmp;       assign b4.mem_jump = jmp;
  assign b16.mem_jump_mem = jmem;  assign b4.mem_jump_mem = jmem;

  hazard_ctrl #(.CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  hazard_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(b4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_rs = 6'd0; id_rt = 6'd0; uses_rt = 1'b0; ex_rd = 6'd0; ex_we = 1'b0;
    mem_rd = 6'd0; mem_we = 1'b0; z = 1'b0; n = 1'b0; brz = 1'b0; brn = 1'b0;
    jmp = 1'b0; jmem = 1'b0;
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // One clock: check Mealy outputs mid-cycle, advance the model, check counters after the edge.
  task automatic cycle();
    bit tk, exh, mh, stall;
    int need;
    @(negedge clk);
    #1;
    tk  = (brz && z) || (brn && n) || jmp || jmem;
    exh = ex_we && ex_rd != 0 && (ex_rd == id_rs || (uses_rt && ex_rd == id_rt));
    mh  = mem_we && mem_rd != 0 && (mem_rd == id_rs || (uses_rt && mem_rd == id_rt));
    need = exh ? 2 : (mh ? 1 : 0);
    if (!rst_n) begin
      pend = 0; sc16 = 0; fe16 = 0; sc4 = 0; fe4 = 0;
      tk = 1'b0;
      stall = 1'b0;
    end else begin
      stall = !tk && (pend > 0 || need > 0);
    end
    chk("pc_write",    32'(b16.pc_write),    32'(!stall));
    chk("ifid_write",  32'(b16.ifid_write),  32'(!stall));
    chk("idex_bubble", 32'(b16.idex_bubble), 32'(stall));
    chk("ifid_flush",  32'(b16.ifid_flush),  32'(tk));
    chk("idex_flush",  32'(b16.idex_flush),  32'(tk));
    chk("exmem_flush", 32'(b16.exmem_flush), 32'(tk));
    chk("bubble_w4",   32'(b4.idex_bubble),  32'(stall));
    @(posedge clk);
    if (rst_n) begin
      if (tk) pend = 0;
      else if (pend > 0) pend--;
      else pend = (need > 0) ? need - 1 : 0;
      if (stall) begin sc16 = sat(sc16, 65535); sc4 = sat(sc4, 15); end
      if (tk)    begin fe16 = sat(fe16, 65535); fe4 = sat(fe4, 15); end
    end
    #1;
    chk("stall_cycles16", 32'(b16.stall_cycles), 32'(sc16));
    chk("flush_events16", 32'(b16.flush_events), 32'(fe16));
    chk("stall_cycles4",  32'(b4.stall_cycles),  32'(sc4));
    chk("flush_events4",  32'(b4.flush_events),  32'(fe4));
  endtask

  initial begin
    // Reset holds free-run outputs even with a hazard and a jump present.
    clr();
    id_rs = 6'd5; ex_rd = 6'd5; ex_we = 1'b1; jmp = 1'b1;
    cycle();
    jmp = 1'b0;
    cycle();
    chk("reset_stall_cycles", 32'(b16.stall_cycles), 32'd0);
    clr();
    rst_n = 1'b1;
    cycle();

    // EX-stage producer: two-cycle stall while it advances to MEM then WB.
    id_rs = 6'd5; ex_rd = 6'd5; ex_we = 1'b1;
    cycle();
    ex_we = 1'b0; mem_rd = 6'd5; mem_we = 1'b1;
    cycle();
    mem_we = 1'b0;
    cycle();
    chk("two_cycle_stall_total", 32'(b16.stall_cycles), 32'd2);

    // MEM-stage producer on rt: one-cycle stall only when rt is really read.
    clr();
    id_rt = 6'd7; uses_rt = 1'b1; mem_rd = 6'd7; mem_we = 1'b1;
    cycle();
    clr();
    cycle();
    chk("one_cycle_stall_total", 32'(b16.stall_cycles), 32'd3);
    id_rt = 6'd7; uses_rt = 1'b0; mem_rd = 6'd7; mem_we = 1'b1;
    cycle();

    // Register zero never stalls; taken BrZ flushes once.
    clr();
    ex_rd = 6'd0; ex_we = 1'b1; id_rs = 6'd0;
    cycle();
    clr();
    brz = 1'b1; z = 1'b1;
    cycle();
    chk("flush_once", 32'(b16.flush_events), 32'd1);
    clr();
    cycle();

    // Jump arriving mid-stall overrides the stall and returns to idle.
    id_rs = 6'd3; ex_rd = 6'd3; ex_we = 1'b1;
    cycle();
    jmp = 1'b1;
    cycle();
    clr();
    cycle();
    chk("idle_after_flush", 32'(b16.pc_write), 32'd1);

    // Held hazard saturates the 4-bit counter; async reset aborts mid-stall.
    id_rs = 6'd9; ex_rd = 6'd9; ex_we = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    chk("sat4", 32'(b4.stall_cycles), 32'd15);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    pend = 0; sc16 = 0; fe16 = 0; sc4 = 0; fe4 = 0;
    chk("async_rst_sc", 32'(b16.stall_cycles), 32'd0);
    chk("async_rst_sc4", 32'(b4.stall_cycles), 32'd0);
    chk("async_rst_pc", 32'(b16.pc_write), 32'd1);
    cycle();
    clr();
    rst_n = 1'b1;
    cycle();

    // Randomized traffic over a small register set to provoke frequent hits.
    for (int i = 0; i < 400; i++) begin
      id_rs   = 6'($urandom_range(0, 3));
      id_rt   = 6'($urandom_range(0, 3));
      uses_rt = 1'($urandom_range(0, 1));
      ex_rd   = 6'($urandom_range(0, 3));
      ex_we   = 1'($urandom_range(0, 1));
      mem_rd  = 6'($urandom_range(0, 3));
      mem_we  = 1'($urandom_range(0, 1));
      z       = 1'($urandom_range(0, 1));
      n       = 1'($urandom_range(0, 1));
      brz     = ($urandom_range(0, 7) == 0);
      brn     = ($urandom_range(0, 7) == 0);
      jmp     = ($urandom_range(0, 15) == 0);
      jmem    = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of both statistics counters.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: id_rs  in  6  source register index of the instruction in ID.
REQ-005 SHALL have port: id_rt  in  6  second source register index of the instruction in ID.
REQ-006 SHALL have port: id_uses_rt  in  1  1 = id_rt is a real read.
REQ-007 SHALL have port: ex_rd, ex_RegWrite  in  6, 1  destination and write enable from ID/EX outputs.
REQ-008 SHALL have port: mem_rd, mem_RegWrite  in  6, 1  destination and write enable from EX/MEM outputs.
REQ-009 SHALL have port: mem_Z, mem_N, mem_BrZ, mem_BrN, mem_jump, mem_jump_mem  in  1 each  flags and branch controls from EX/MEM outputs.
REQ-010 SHALL have port: pc_write, ifid_write  out  1 each  1 = PC / IF-ID buffer may load.
REQ-011 SHALL have port: idex_bubble  out  1  1 = ID/EX loads all-zero control (NOP).
REQ-012 SHALL have port: ifid_flush, idex_flush, exmem_flush  out  1 each  1 = buffer loads NOP.
REQ-013 SHALL have port: stall_cycles, flush_events  out  CNT_W each  saturating statistics.

Function
REQ-014 SHALL compute taken = (mem_BrZ & mem_Z) | (mem_BrN & mem_N) | mem_jump | mem_jump_mem.
REQ-015 SHALL treat register index 0 as never hazardous (hardwired zero); match requires RegWrite=1 and rd!=0.
REQ-016 SHALL flag ex_hit when ex_rd matches id_rs, or id_rt with id_uses_rt=1; mem_hit likewise against mem_rd.
REQ-017 SHALL derive need = 2 if ex_hit, else 1 if mem_hit, else 0 (EX match wins when both hit); WB-stage writes need no stall.
REQ-018 SHALL implement FSM states IDLE and STALL plus a 2-bit remaining-cycle register rem.
REQ-019 IDLE, taken=1: assert ifid_flush, idex_flush, exmem_flush, pc_write=1, ifid_write=1, idex_bubble=0 same cycle; stay IDLE; hazard ignored.
REQ-020 IDLE, taken=0, need=1: pc_write=0, ifid_write=0, idex_bubble=1 this cycle; stay IDLE.
REQ-021 IDLE, taken=0, need=2: same stall outputs this cycle; rem<=1; next state STALL.
REQ-022 IDLE, taken=0, need=0: pc_write=1, ifid_write=1, all bubble/flush outputs 0.
REQ-023 STALL, taken=0: pc_write=0, ifid_write=0, idex_bubble=1 regardless of hazard inputs; rem<=rem-1; go IDLE when rem==1.
REQ-024 STALL, taken=1: flush behaviour of REQ-019 overrides stall; next state IDLE; rem<=0.
REQ-025 All outputs except counters SHALL be combinational from state and current inputs (Mealy), zero added latency.
REQ-026 stall_cycles SHALL increment by 1 on each rising edge where idex_bubble=1, saturating at all-ones.
REQ-027 flush_events SHALL increment by 1 on each rising edge where taken=1, saturating at all-ones.
REQ-028 Total stall for need=2 SHALL be exactly 2 cycles; need=1 exactly 1 cycle.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, rem=0, stall_cycles=0, flush_events=0.
REQ-030 While rst_n=0: pc_write=1, ifid_write=1, idex_bubble=0, all flush outputs 0, independent of inputs.
REQ-031 Reset asserted mid-STALL SHALL abort the stall; first cycle after release evaluates as IDLE.

Verification
REQ-032 id_rs=5, ex_rd=5, ex_RegWrite=1 then producer advances -> idex_bubble=1 for 2 cycles, pc_write=0 both, stall_cycles=2.
REQ-033 id_rt=7, id_uses_rt=1, mem_rd=7, mem_RegWrite=1 -> 1-cycle stall; same with id_uses_rt=0 -> no stall.
REQ-034 ex_rd=0, ex_RegWrite=1, id_rs=0 -> no stall; mem_BrZ=1, mem_Z=1 -> three flushes 1 cycle, flush_events=1.
REQ-035 Enter STALL (need=2), next cycle mem_jump=1 -> flushes asserted, idex_bubble=0, pc_write=1, IDLE next cycle.
REQ-036 CNT_W=4, hold hazard 20 cycles -> stall_cycles saturates at 15; rst_n pulse low mid-stall -> counters 0, pc_write=1 immediately.
